// File: rtl/weight_tile_counter.sv
// weight_tile_counter: walks a runtime-sized 2-D weight tile (column inner, row outer)
// under a valid/ready step handshake, producing indices, flat address and sweep flags.
module weight_tile_counter #(
    parameter int unsigned WEIGHT_COLS          = 3,
    parameter int unsigned WEIGHT_ROWS          = 3,
    parameter int unsigned COUNTER_WEIGHT_WIDTH = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1,
    parameter int unsigned COUNTER_ROW_WIDTH    = (WEIGHT_ROWS > 1) ? $clog2(WEIGHT_ROWS) : 1,
    parameter int unsigned ADDR_WIDTH           = ((WEIGHT_COLS * WEIGHT_ROWS) > 1) ?
                                                  $clog2(WEIGHT_COLS * WEIGHT_ROWS) : 1,
    parameter int unsigned CFG_COL_WIDTH        = $clog2(WEIGHT_COLS + 1),
    parameter int unsigned CFG_ROW_WIDTH        = $clog2(WEIGHT_ROWS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CFG_COL_WIDTH-1:0]        cols_cfg,
    input  logic [CFG_ROW_WIDTH-1:0]        rows_cfg,
    input  logic                            step_valid,
    output logic                            step_ready,
    output logic [COUNTER_WEIGHT_WIDTH-1:0] weight_count,
    output logic [COUNTER_ROW_WIDTH-1:0]    row_count,
    output logic [ADDR_WIDTH-1:0]           weight_addr,
    output logic                            last,
    output logic                            col_wrap,
    output logic                            done,
    output logic                            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state;
    logic [CFG_COL_WIDTH-1:0] cols_lat;
    logic [CFG_ROW_WIDTH-1:0] rows_lat;
    logic [CFG_COL_WIDTH-1:0] cols_clamped;
    logic [CFG_ROW_WIDTH-1:0] rows_clamped;
    logic                     col_at_end;
    logic                     row_at_end;
    logic                     step_accept;

    // Clamp requested extents into 1..max before they are latched
    always_comb begin
        cols_clamped = cols_cfg;
        if (cols_cfg == '0) begin
            cols_clamped = CFG_COL_WIDTH'(1);
        end else if (cols_cfg > CFG_COL_WIDTH'(WEIGHT_COLS)) begin
            cols_clamped = CFG_COL_WIDTH'(WEIGHT_COLS);
        end
        rows_clamped = rows_cfg;
        if (rows_cfg == '0) begin
            rows_clamped = CFG_ROW_WIDTH'(1);
        end else if (rows_cfg > CFG_ROW_WIDTH'(WEIGHT_ROWS)) begin
            rows_clamped = CFG_ROW_WIDTH'(WEIGHT_ROWS);
        end
    end

    // Position decode against the latched extents, plus the flat address
    always_comb begin
        col_at_end  = (CFG_COL_WIDTH'(weight_count) == (cols_lat - CFG_COL_WIDTH'(1)));
        row_at_end  = (CFG_ROW_WIDTH'(row_count) == (rows_lat - CFG_ROW_WIDTH'(1)));
        step_accept = step_valid && step_ready;
        last        = busy && col_at_end && row_at_end;
        weight_addr = (ADDR_WIDTH'(row_count) * ADDR_WIDTH'(cols_lat)) + ADDR_WIDTH'(weight_count);
    end

    // Sweep controller: latches config on start, advances counters on accepted steps
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            weight_count <= '0;
            row_count    <= '0;
            col_wrap     <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            step_ready   <= 1'b0;
            cols_lat     <= CFG_COL_WIDTH'(1);
            rows_lat     <= CFG_ROW_WIDTH'(1);
        end else begin
            col_wrap <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cols_lat     <= cols_clamped;
                        rows_lat     <= rows_clamped;
                        weight_count <= '0;
                        row_count    <= '0;
                        busy         <= 1'b1;
                        step_ready   <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (step_accept) begin
                        if (col_at_end) begin
                            weight_count <= '0;
                            col_wrap     <= 1'b1;
                            if (row_at_end) begin
                                row_count  <= '0;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                step_ready <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                row_count <= COUNTER_ROW_WIDTH'(row_count + 1'b1);
                            end
                        end else begin
                            weight_count <= COUNTER_WEIGHT_WIDTH'(weight_count + 1'b1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_tile_counter.sv
// Randomised and directed bench for weight_tile_counter against a linear-index reference model.
module tb_weight_tile_counter;

    localparam int unsigned WC  = 3;
    localparam int unsigned WR  = 3;
    localparam int unsigned CWW = (WC > 1) ? $clog2(WC) : 1;
    localparam int unsigned RWW = (WR > 1) ? $clog2(WR) : 1;
    localparam int unsigned AW  = ((WC * WR) > 1) ? $clog2(WC * WR) : 1;
    localparam int unsigned CCW = $clog2(WC + 1);
    localparam int unsigned RCW = $clog2(WR + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [CCW-1:0] cols_cfg;
    logic [RCW-1:0] rows_cfg;
    logic           step_valid;
    logic           step_ready;
    logic [CWW-1:0] weight_count;
    logic [RWW-1:0] row_count;
    logic [AW-1:0]  weight_addr;
    logic           last;
    logic           col_wrap;
    logic           done;
    logic           busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    int done_seen;

    // Reference state: sweep held as a count of accepted steps k
    int m_busy, m_k, m_cols, m_rows, m_wrap, m_done;

    always #5 clk = ~clk;

    weight_tile_counter #(
        .WEIGHT_COLS(WC),
        .WEIGHT_ROWS(WR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cols_cfg    (cols_cfg),
        .rows_cfg    (rows_cfg),
        .step_valid  (step_valid),
        .step_ready  (step_ready),
        .weight_count(weight_count),
        .row_count   (row_count),
        .weight_addr (weight_addr),
        .last        (last),
        .col_wrap    (col_wrap),
        .done        (done),
        .busy        (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int clampv(input int v, input int mx);
        if (v == 0) return 1;
        if (v > mx) return mx;
        return v;
    endfunction

    // Advance the reference by one clock using the inputs the DUT just sampled
    task automatic model_step();
        if (reset) begin
            m_busy = 0; m_k = 0; m_cols = 1; m_rows = 1; m_wrap = 0; m_done = 0;
        end else begin
            m_wrap = 0;
            m_done = 0;
            if (m_busy == 0) begin
                if (start) begin
                    m_cols = clampv(int'(cols_cfg), WC);
                    m_rows = clampv(int'(rows_cfg), WR);
                    m_k    = 0;
                    m_busy = 1;
                end
            end else if (step_valid) begin
                m_k = m_k + 1;
                if (m_k % m_cols == 0) m_wrap = 1;
                if (m_k == m_cols * m_rows) begin
                    m_done = 1;
                    m_busy = 0;
                    m_k    = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("step_ready",   int'(step_ready),   m_busy);
        chk("busy",         int'(busy),         m_busy);
        chk("weight_count", int'(weight_count), m_k % m_cols);
        chk("row_count",    int'(row_count),    m_k / m_cols);
        chk("weight_addr",  int'(weight_addr),  m_k);
        chk("last",         int'(last),         (m_busy != 0 && m_k == m_cols * m_rows - 1) ? 1 : 0);
        chk("col_wrap",     int'(col_wrap),     m_wrap);
        chk("done",         int'(done),         m_done);
        done_seen += int'(done);
    endtask

    // One clock: drive after the falling edge, model on the rising edge, check at the next falling edge
    task automatic cyc(input logic rs, input logic st, input int c, input int r, input logic sv);
        reset      = rs;
        start      = st;
        cols_cfg   = CCW'(c);
        rows_cfg   = RCW'(r);
        step_valid = sv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cols_cfg = '0; rows_cfg = '0; step_valid = 1'b0;
        m_busy = 0; m_k = 0; m_cols = 1; m_rows = 1; m_wrap = 0; m_done = 0;
        done_seen = 0;
        @(negedge clk);

        // Reset dominates start and step
        cyc(1'b1, 1'b1, 3, 3, 1'b1);
        cyc(1'b1, 1'b1, 3, 3, 1'b1);
        chk("rst_addr", int'(weight_addr), 0);
        chk("rst_busy", int'(busy), 0);

        // Full 3x3 sweep with step_valid held high
        cyc(1'b0, 1'b1, 3, 3, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 9; i++) begin
            chk("sweep_addr_seq", int'(weight_addr), i);
            cyc(1'b0, 1'b0, 3, 3, 1'b1);
        end
        chk("sweep_done_pulse", int'(done), 1);
        chk("sweep_done_count", done_seen, 1);
        cyc(1'b0, 1'b0, 3, 3, 1'b0);

        // 2x2 with gapped steps
        cyc(1'b0, 1'b1, 2, 2, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 2, 2, (i % 2 == 0) ? 1'b1 : 1'b0);
        chk("gap_done_count", done_seen, 1);

        // Clamp: 0 columns -> 1, oversize rows -> max
        cyc(1'b0, 1'b1, 0, 7, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 7, 1'b1);
        chk("clamp_done_count", done_seen, 1);
        cyc(1'b0, 1'b0, 0, 0, 1'b0);

        // Start and cfg change mid-sweep are ignored
        cyc(1'b0, 1'b1, 3, 3, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 3, 3, 1'b1);
        cyc(1'b0, 1'b1, 1, 1, 1'b0);
        chk("midstart_addr", int'(weight_addr), 4);
        done_seen = 0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1, 1, 1'b1);
        chk("midstart_done_count", done_seen, 1);

        // Reset mid-sweep aborts without done
        cyc(1'b0, 1'b1, 3, 3, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 3, 3, 1'b1);
        done_seen = 0;
        cyc(1'b1, 1'b0, 3, 3, 1'b1);
        cyc(1'b0, 1'b0, 3, 3, 1'b1);
        chk("abort_done_count", done_seen, 0);

        // 1x1: one step finishes; restart in the done cycle is accepted
        cyc(1'b0, 1'b1, 1, 1, 1'b0);
        cyc(1'b0, 1'b0, 1, 1, 1'b1);
        chk("one_done", int'(done), 1);
        chk("one_wrap", int'(col_wrap), 1);
        cyc(1'b0, 1'b1, 1, 1, 1'b0);
        chk("one_restart_busy", int'(busy), 1);
        cyc(1'b0, 1'b0, 1, 1, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                int'($urandom_range(0, (1 << CCW) - 1)),
                int'($urandom_range(0, (1 << RCW) - 1)),
                ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
